// File: rtl/rf_multiport_pkg.sv
// Shared defaults, types and the index-validity helper for the multiport register file.
package rf_multiport_pkg;

    localparam int unsigned RF_DATA_W   = 8;
    localparam int unsigned RF_NUM_REGS = 14;
    localparam int unsigned RF_ADDR_W   = 4;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    // True when idx names a register that may be written, claimed, bypassed or read as stored.
    function automatic logic rf_writable(input int unsigned idx,
                                         input int unsigned num_regs,
                                         input logic        zero_reg);
        return (idx < num_regs) && !(zero_reg && (idx == 0));
    endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// Decode/writeback-facing bundle of the register file: read, write, claim and debug views.
interface rf_multiport_if #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 14,
    parameter int unsigned ADDR_W   = 4
) ();
    logic                       rf_write_reg;
    logic [ADDR_W-1:0]          rf_reg_in;
    logic [DATA_W-1:0]          rf_write_data;
    logic [ADDR_W-1:0]          rf_rd_a;
    logic [ADDR_W-1:0]          rf_rd_b;
    logic [DATA_W-1:0]          rf_out_a;
    logic [DATA_W-1:0]          rf_out_b;
    logic                       rf_claim;
    logic [ADDR_W-1:0]          rf_claim_reg;
    logic                       rf_stall;
    logic [NUM_REGS-1:0]        rf_busy;
    logic [NUM_REGS*DATA_W-1:0] rs;

    modport master (
        output rf_write_reg, rf_reg_in, rf_write_data, rf_rd_a, rf_rd_b, rf_claim, rf_claim_reg,
        input  rf_out_a, rf_out_b, rf_stall, rf_busy, rs
    );

    modport slave (
        input  rf_write_reg, rf_reg_in, rf_write_data, rf_rd_a, rf_rd_b, rf_claim, rf_claim_reg,
        output rf_out_a, rf_out_b, rf_stall, rf_busy, rs
    );
endinterface

// File: rtl/rf_multiport_busy_table.sv
// Per-register pending-writeback flags and the read-side stall they cause.
module rf_multiport_busy_table
    import rf_multiport_pkg::*;
#(
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_claim,
    input  logic [ADDR_W-1:0]   i_claim_reg,
    input  logic                i_clr,
    input  logic [ADDR_W-1:0]   i_clr_reg,
    input  logic [ADDR_W-1:0]   i_rd_a,
    input  logic [ADDR_W-1:0]   i_rd_b,
    input  logic                i_byp_a,
    input  logic                i_byp_b,
    output logic [NUM_REGS-1:0] o_busy,
    output logic                o_stall_c
);
    logic [NUM_REGS-1:0] r_busy;
    logic                w_claim_v;
    logic                w_busy_a;
    logic                w_busy_b;

    assign w_claim_v = i_claim && rf_writable(32'(i_claim_reg), NUM_REGS, ZERO_REG != 0);

    // Claim sets, writeback clears; a claim in the same cycle as its own writeback wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_claim_v && (i_claim_reg == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (i_clr && (i_clr_reg == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Busy lookup per read port; indices outside the table never match and never stall.
    always_comb begin
        w_busy_a = 1'b0;
        w_busy_b = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (i_rd_a == ADDR_W'(i)) w_busy_a = r_busy[i];
            if (i_rd_b == ADDR_W'(i)) w_busy_b = r_busy[i];
        end
    end

    assign o_busy    = r_busy;
    assign o_stall_c = (w_busy_a && !i_byp_a) || (w_busy_b && !i_byp_b);

endmodule

// File: rtl/rf_multiport.sv
// Register file: one write port, two bypassed combinational read ports, busy scoreboard.
module rf_multiport
    import rf_multiport_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic           clk,
    input  logic           reset,
    rf_multiport_if.slave  bus
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_we_v;
    logic              w_byp_a;
    logic              w_byp_b;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_stall_c;

    assign w_we_v  = bus.rf_write_reg && rf_writable(32'(bus.rf_reg_in), NUM_REGS, ZERO_REG != 0);
    assign w_byp_a = w_we_v && (bus.rf_rd_a == bus.rf_reg_in);
    assign w_byp_b = w_we_v && (bus.rf_rd_b == bus.rf_reg_in);

    // Storage; invalid or hard-zero targets are filtered out by w_we_v.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
        end else if (w_we_v) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (bus.rf_reg_in == ADDR_W'(i)) r_regs[i] <= bus.rf_write_data;
            end
        end
    end

    // Stored-value read muxes; out-of-range and hard-zero indices fall through to 0.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (!((ZERO_REG != 0) && (i == 0))) begin
                if (bus.rf_rd_a == ADDR_W'(i)) w_rd_a = r_regs[i];
                if (bus.rf_rd_b == ADDR_W'(i)) w_rd_b = r_regs[i];
            end
        end
    end

    rf_multiport_busy_table #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk         (clk),
        .reset       (reset),
        .i_claim     (bus.rf_claim),
        .i_claim_reg (bus.rf_claim_reg),
        .i_clr       (w_we_v),
        .i_clr_reg   (bus.rf_reg_in),
        .i_rd_a      (bus.rf_rd_a),
        .i_rd_b      (bus.rf_rd_b),
        .i_byp_a     (w_byp_a),
        .i_byp_b     (w_byp_b),
        .o_busy      (bus.rf_busy),
        .o_stall_c   (w_stall_c)
    );

    // Reset forces the read ports quiet even while a write is presented.
    assign bus.rf_out_a = reset ? '0 : (w_byp_a ? bus.rf_write_data : w_rd_a);
    assign bus.rf_out_b = reset ? '0 : (w_byp_b ? bus.rf_write_data : w_rd_b);
    assign bus.rf_stall = !reset && w_stall_c;

    // Flat debug view of every register.
    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_rs
        assign bus.rs[g*DATA_W +: DATA_W] = r_regs[g];
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboarded random + directed bench for rf_multiport against an array-based reference.
module tb_rf_multiport;
    import rf_multiport_pkg::*;

    localparam int unsigned DW = RF_DATA_W;
    localparam int unsigned NR = RF_NUM_REGS;
    localparam int unsigned AW = RF_ADDR_W;

    logic clk = 1'b0;
    logic reset;

    rf_multiport_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) bus ();
    rf_multiport_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) bus_z ();

    rf_multiport #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_REG(0)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    rf_multiport #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .bus(bus_z));

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]    out_a;
        logic [DW-1:0]    out_b;
        logic             stall;
        logic [NR-1:0]    busy;
        logic [NR*DW-1:0] rs;
    } exp_t;

    exp_t     q[$];
    exp_t     mon_e;
    rf_data_t m_regs[NR];
    bit       m_busy[NR];
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: register file as an array, bypass as "the write being presented".
    function automatic rf_data_t m_read(input int idx, input bit we, input int win, input int wd);
        if (idx >= int'(NR)) return '0;
        if (we && win == idx) return rf_data_t'(wd);
        return m_regs[idx];
    endfunction

    function automatic bit m_stall_one(input int idx, input bit we, input int win);
        if (idx >= int'(NR)) return 1'b0;
        return m_busy[idx] && !(we && win == idx);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < int'(NR); i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        bus.rf_write_reg = 1'b0; bus.rf_reg_in = '0; bus.rf_write_data = '0;
        bus.rf_rd_a = '0; bus.rf_rd_b = '0; bus.rf_claim = 1'b0; bus.rf_claim_reg = '0;
    endtask

    // One cycle of stimulus: drive, predict what the DUT shows this cycle, advance the model.
    task automatic step(input bit we, input int win, input int wd, input int ra, input int rb,
                        input bit cl, input int cr);
        exp_t e;
        @(posedge clk);
        #1;
        bus.rf_write_reg  = we;
        bus.rf_reg_in     = AW'(win);
        bus.rf_write_data = DW'(wd);
        bus.rf_rd_a       = AW'(ra);
        bus.rf_rd_b       = AW'(rb);
        bus.rf_claim      = cl;
        bus.rf_claim_reg  = AW'(cr);
        e.out_a = m_read(ra, we, win, wd);
        e.out_b = m_read(rb, we, win, wd);
        e.stall = m_stall_one(ra, we, win) || m_stall_one(rb, we, win);
        for (int i = 0; i < int'(NR); i++) begin
            e.busy[i]         = m_busy[i];
            e.rs[i*DW +: DW]  = m_regs[i];
        end
        q.push_back(e);
        if (we && win < int'(NR)) begin
            m_regs[win] = rf_data_t'(wd);
            m_busy[win] = 1'b0;
        end
        if (cl && cr < int'(NR)) m_busy[cr] = 1'b1;
    endtask

    // Monitor: outputs are combinational, so they are sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("out_a", 128'(bus.rf_out_a), 128'(mon_e.out_a));
            check("out_b", 128'(bus.rf_out_b), 128'(mon_e.out_b));
            check("stall", 128'(bus.rf_stall), 128'(mon_e.stall));
            check("busy",  128'(bus.rf_busy),  128'(mon_e.busy));
            check("rs",    128'(bus.rs),       128'(mon_e.rs));
        end
    end

    initial begin
        int wi, ri;
        m_clear();
        // Reset asserted with a write and claim pending: everything reads zero with no edge.
        reset = 1'b1;
        bus.rf_write_reg = 1'b1; bus.rf_reg_in = AW'(1); bus.rf_write_data = 8'h55;
        bus.rf_rd_a = AW'(1); bus.rf_rd_b = AW'(1); bus.rf_claim = 1'b1; bus.rf_claim_reg = AW'(1);
        bus_z.rf_write_reg = 1'b0; bus_z.rf_reg_in = '0; bus_z.rf_write_data = '0;
        bus_z.rf_rd_a = '0; bus_z.rf_rd_b = '0; bus_z.rf_claim = 1'b0; bus_z.rf_claim_reg = '0;
        #3;
        check("rst_rs",    128'(bus.rs),       128'(0));
        check("rst_busy",  128'(bus.rf_busy),  128'(0));
        check("rst_stall", 128'(bus.rf_stall), 128'(0));
        check("rst_out_a", 128'(bus.rf_out_a), 128'(0));
        @(posedge clk); #1;
        check("rst_rs_edge",   128'(bus.rs),      128'(0));
        check("rst_busy_edge", 128'(bus.rf_busy), 128'(0));
        idle();
        reset = 1'b0;

        // Directed sequence.
        step(1, 7,  8'h02, 0, 0, 0, 0);
        step(1, 13, 8'h4A, 7, 0, 0, 0);
        step(0, 0,  0,     7, 13, 0, 0);
        step(1, 5,  8'hC3, 5, 13, 0, 0);
        step(0, 0,  0,     5, 7, 1, 3);
        step(0, 0,  0,     0, 3, 0, 0);
        step(1, 3,  8'h11, 7, 3, 0, 0);
        step(0, 0,  0,     0, 3, 0, 0);
        step(1, 9,  8'h55, 9, 9, 1, 9);
        step(0, 0,  0,     9, 9, 0, 0);
        step(1, 14, 8'hEE, 15, 14, 1, 14);
        step(0, 0,  0,     15, 9, 0, 0);
        step(1, 2,  8'h77, 2, 9, 0, 0);

        // Random traffic, reads biased toward the write target to exercise bypass.
        for (int n = 0; n < 300; n++) begin
            wi = int'($urandom_range(0, 15));
            ri = ($urandom_range(0, 2) == 0) ? wi : int'($urandom_range(0, 15));
            step(($urandom_range(0, 1) == 1), wi, int'($urandom_range(0, 255)),
                 ri, int'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)));
        end
        step(1, 2, 8'h77, 2, 2, 0, 0);
        step(0, 0, 0, 2, 2, 0, 0);

        // Async reset mid-cycle with a claim and write to reg2 pending.
        @(posedge clk); #1;
        bus.rf_write_reg = 1'b1; bus.rf_reg_in = AW'(2); bus.rf_write_data = 8'hFF;
        bus.rf_claim = 1'b1; bus.rf_claim_reg = AW'(2); bus.rf_rd_a = AW'(2); bus.rf_rd_b = AW'(2);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_reg2",  128'(bus.rs[2*DW +: DW]), 128'(0));
        check("mid_rst_busy2", 128'(bus.rf_busy[2]),     128'(0));
        check("mid_rst_rs",    128'(bus.rs),             128'(0));
        check("mid_rst_out_a", 128'(bus.rf_out_a),       128'(0));
        check("mid_rst_stall", 128'(bus.rf_stall),       128'(0));
        @(posedge clk); #1;
        check("mid_rst_reg2_edge",  128'(bus.rs[2*DW +: DW]), 128'(0));
        check("mid_rst_busy2_edge", 128'(bus.rf_busy[2]),     128'(0));
        idle();
        reset = 1'b0;
        m_clear();
        step(0, 0, 0, 2, 3, 0, 0);
        step(1, 4, 8'h9D, 4, 2, 1, 6);
        step(0, 0, 0, 4, 6, 0, 0);

        // Hard-zero build: register 0 ignores writes and claims; others behave normally.
        @(posedge clk); #1;
        idle();
        bus_z.rf_write_reg = 1'b1; bus_z.rf_reg_in = '0; bus_z.rf_write_data = 8'hAA;
        bus_z.rf_rd_a = '0; bus_z.rf_rd_b = '0; bus_z.rf_claim = 1'b1; bus_z.rf_claim_reg = '0;
        #2;
        check("z_byp_a",  128'(bus_z.rf_out_a), 128'(0));
        check("z_stall0", 128'(bus_z.rf_stall), 128'(0));
        @(posedge clk); #1;
        bus_z.rf_reg_in = AW'(1); bus_z.rf_write_data = 8'h3C; bus_z.rf_rd_b = AW'(1);
        bus_z.rf_claim = 1'b0;
        #2;
        check("z_reg0_rs",   128'(bus_z.rs[DW-1:0]),  128'(0));
        check("z_reg0_busy", 128'(bus_z.rf_busy[0]),  128'(0));
        check("z_out_a0",    128'(bus_z.rf_out_a),    128'(0));
        check("z_byp_b1",    128'(bus_z.rf_out_b),    128'(8'h3C));
        @(posedge clk); #1;
        bus_z.rf_write_reg = 1'b0;
        #2;
        check("z_reg1_rs",   128'(bus_z.rs[DW +: DW]), 128'(8'h3C));
        check("z_out_b1",    128'(bus_z.rf_out_b),     128'(8'h3C));

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        check("drain", 128'(q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
